// File: rtl/drawing_priority_n.sv
// Priority compositor for N_LAYERS layers (layer 0 on top) with optional per-frame
// collision statistics, compiled only when DRAWING_COLLISION_EN is defined.
module drawing_priority_n #(
    parameter int N_LAYERS = 4,
    parameter int CW       = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     frame_start,
    input  logic [N_LAYERS-1:0]      layer_en,
    input  logic [N_LAYERS-1:0]      draw,
    input  logic [N_LAYERS*3*CW-1:0] rgb,
    input  logic [3*CW-1:0]          rgb_bg,
    output logic [CW-1:0]            Red_level,
    output logic [CW-1:0]            Green_level,
    output logic [CW-1:0]            Blue_level,
    output logic                     draw_any,
    output logic [2:0]               top_layer,
    output logic [N_LAYERS-1:0]      coll_live,
    output logic [N_LAYERS-1:0]      coll_frame,
    output logic [15:0]              coll_pixels,
    output logic                     coll_valid
);

    logic [N_LAYERS-1:0] active;
    logic [3*CW-1:0]     win_rgb;
    logic                win_any;
    logic [2:0]          win_idx;

    assign active = draw & layer_en;

    // Scan from the bottom layer upward so the lowest active index is the last to assign.
    always_comb begin
        win_rgb = rgb_bg;
        win_any = 1'b0;
        win_idx = 3'd0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_rgb = rgb[i*3*CW +: 3*CW];
                win_any = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            Red_level   <= '0;
            Green_level <= '0;
            Blue_level  <= '0;
            draw_any    <= 1'b0;
            top_layer   <= 3'd0;
        end else begin
            Red_level   <= win_rgb[3*CW-1 -: CW];
            Green_level <= win_rgb[2*CW-1 -: CW];
            Blue_level  <= win_rgb[CW-1 -: CW];
            draw_any    <= win_any;
            top_layer   <= win_idx;
        end
    end

`ifdef DRAWING_COLLISION_EN
    logic [N_LAYERS-1:0] acc;
    logic [N_LAYERS-1:0] snap_flags;
    logic [15:0]         pix_cnt;
    logic [15:0]         snap_cnt;
    logic                snap_valid;
    logic                is_coll;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign is_coll = |(active & (active - N_LAYERS'(1)));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc        <= '0;
            pix_cnt    <= 16'd0;
            snap_flags <= '0;
            snap_cnt   <= 16'd0;
            snap_valid <= 1'b0;
        end else if (frame_start) begin
            snap_flags <= acc;
            snap_cnt   <= pix_cnt;
            snap_valid <= 1'b1;
            acc        <= is_coll ? active : '0;
            pix_cnt    <= is_coll ? 16'd1 : 16'd0;
        end else begin
            snap_valid <= 1'b0;
            if (is_coll) begin
                acc <= acc | active;
                if (pix_cnt != 16'hFFFF) begin
                    pix_cnt <= pix_cnt + 16'd1;
                end
            end
        end
    end

    assign coll_live   = acc;
    assign coll_frame  = snap_flags;
    assign coll_pixels = snap_cnt;
    assign coll_valid  = snap_valid;
`else
    logic unused_frame_start;

    assign unused_frame_start = frame_start;
    assign coll_live          = '0;
    assign coll_frame         = '0;
    assign coll_pixels        = 16'd0;
    assign coll_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_drawing_priority_n.sv
// Directed bench for drawing_priority_n; collision expectations follow DRAWING_COLLISION_EN.
module tb_drawing_priority_n;

    localparam int N  = 4;
    localparam int CW = 4;
`ifdef DRAWING_COLLISION_EN
    localparam bit COL = 1'b1;
`else
    localparam bit COL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetN;
    logic              frame_start;
    logic [N-1:0]      layer_en;
    logic [N-1:0]      draw;
    logic [N*3*CW-1:0] rgb;
    logic [3*CW-1:0]   rgb_bg;
    logic [CW-1:0]     Red_level;
    logic [CW-1:0]     Green_level;
    logic [CW-1:0]     Blue_level;
    logic              draw_any;
    logic [2:0]        top_layer;
    logic [N-1:0]      coll_live;
    logic [N-1:0]      coll_frame;
    logic [15:0]       coll_pixels;
    logic              coll_valid;

    int vectors     = 0;
    int miscompares = 0;

    drawing_priority_n #(.N_LAYERS(N), .CW(CW)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .frame_start (frame_start),
        .layer_en    (layer_en),
        .draw        (draw),
        .rgb         (rgb),
        .rgb_bg      (rgb_bg),
        .Red_level   (Red_level),
        .Green_level (Green_level),
        .Blue_level  (Blue_level),
        .draw_any    (draw_any),
        .top_layer   (top_layer),
        .coll_live   (coll_live),
        .coll_frame  (coll_frame),
        .coll_pixels (coll_pixels),
        .coll_valid  (coll_valid)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic fs, input logic [N-1:0] en, input logic [N-1:0] dr);
        frame_start = fs;
        layer_en    = en;
        draw        = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %h, wanted %h", tag, obs, exp);
        end
    endtask

    // Packs the pixel outputs as {R,G,B,draw_any,top_layer}.
    function automatic logic [31:0] pix();
        return {16'd0, Red_level, Green_level, Blue_level, draw_any, top_layer};
    endfunction

    function automatic logic [31:0] stats();
        return {7'd0, coll_valid, coll_live, coll_frame, coll_pixels};
    endfunction

    function automatic logic [31:0] exp_stats(input logic v, input logic [N-1:0] live,
                                              input logic [N-1:0] frm, input logic [15:0] cnt);
        return COL ? {7'd0, v, live, frm, cnt} : 32'd0;
    endfunction

    initial begin
        resetN      = 1'b0;
        frame_start = 1'b0;
        layer_en    = '0;
        draw        = '0;
        rgb         = {12'h00F, 12'h0F0, 12'hF00, 12'h123};
        rgb_bg      = 12'h000;
        #2;
        check_output("reset_pix", pix(), 32'd0);
        check_output("reset_stats", stats(), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        apply_stimulus(1'b0, 4'hF, 4'b0110);
        check_output("layer1_wins", pix(), {16'd0, 4'hF, 4'h0, 4'h0, 1'b1, 3'd1});
        check_output("first_coll", stats(), exp_stats(1'b0, 4'b0110, 4'b0000, 16'd0));

        rgb_bg = 12'hFFF;
        apply_stimulus(1'b0, 4'hF, 4'b0000);
        check_output("background", pix(), {16'd0, 4'hF, 4'hF, 4'hF, 1'b0, 3'd0});

        apply_stimulus(1'b0, 4'b1110, 4'b0011);
        check_output("masked_l0", pix(), {16'd0, 4'hF, 4'h0, 4'h0, 1'b1, 3'd1});
        check_output("masked_nocoll", stats(), exp_stats(1'b0, 4'b0110, 4'b0000, 16'd0));

        apply_stimulus(1'b0, 4'hF, 4'b1000);
        check_output("layer3_only", pix(), {16'd0, 4'h0, 4'h0, 4'hF, 1'b1, 3'd3});

        apply_stimulus(1'b0, 4'hF, 4'b1111);
        check_output("all_layers", pix(), {16'd0, 4'h1, 4'h2, 4'h3, 1'b1, 3'd0});
        check_output("all_coll", stats(), exp_stats(1'b0, 4'b1111, 4'b0000, 16'd0));

        apply_stimulus(1'b1, 4'hF, 4'b0000);
        check_output("snap0", stats(), exp_stats(1'b1, 4'b0000, 4'b1111, 16'd2));

        apply_stimulus(1'b0, 4'hF, 4'b1001);
        check_output("valid_drop", stats(), exp_stats(1'b0, 4'b1001, 4'b1111, 16'd2));
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 4'hF, 4'b1001);
        end
        check_output("five_pix", pix(), {16'd0, 4'h1, 4'h2, 4'h3, 1'b1, 3'd0});

        apply_stimulus(1'b1, 4'hF, 4'b0000);
        check_output("snap_five", stats(), exp_stats(1'b1, 4'b0000, 4'b1001, 16'd5));
        apply_stimulus(1'b0, 4'hF, 4'b0000);
        check_output("valid_one", stats(), exp_stats(1'b0, 4'b0000, 4'b1001, 16'd5));

        apply_stimulus(1'b1, 4'hF, 4'b0110);
        check_output("b2b_a", stats(), exp_stats(1'b1, 4'b0110, 4'b0000, 16'd0));
        apply_stimulus(1'b1, 4'hF, 4'b0000);
        check_output("b2b_b", stats(), exp_stats(1'b1, 4'b0000, 4'b0110, 16'd1));
        apply_stimulus(1'b0, 4'hF, 4'b0000);
        check_output("b2b_end", stats(), exp_stats(1'b0, 4'b0000, 4'b0110, 16'd1));

        frame_start = 1'b0;
        draw        = 4'b0011;
        repeat (70000) @(posedge clk);
        #1;
        apply_stimulus(1'b1, 4'hF, 4'b0000);
        check_output("saturate", stats(), exp_stats(1'b1, 4'b0000, 4'b0011, 16'hFFFF));

        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 4'hF, 4'b1001);
        end
        #2;
        resetN = 1'b0;
        #1;
        check_output("async_pix", pix(), 32'd0);
        check_output("async_stats", stats(), 32'd0);
        draw = 4'b0000;
        #2;
        resetN = 1'b1;

        apply_stimulus(1'b0, 4'hF, 4'b0100);
        check_output("post_rst_pix", pix(), {16'd0, 4'h0, 4'hF, 4'h0, 1'b1, 3'd2});
        apply_stimulus(1'b0, 4'hF, 4'b0101);
        apply_stimulus(1'b0, 4'hF, 4'b0101);
        apply_stimulus(1'b1, 4'hF, 4'b0000);
        check_output("post_rst_snap", stats(), exp_stats(1'b1, 4'b0000, 4'b0101, 16'd2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/drawing_priority_n.md
DRAWING_PRIORITY_N -- requirements
Module: drawing_priority_n

Interface
REQ-001 SHALL provide parameter N_LAYERS, default 4, giving the number of drawable layers (legal range 2..8).
REQ-002 SHALL provide parameter CW, default 4, giving the bits per colour channel.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port frame_start, input, 1 bit: one-cycle pulse marking the first pixel of a frame.
REQ-006 SHALL provide port layer_en, input, N_LAYERS bits: per-layer enable mask.
REQ-007 SHALL provide port draw, input, N_LAYERS bits: per-layer draw request for the current pixel.
REQ-008 SHALL provide port rgb, input, N_LAYERS*3*CW bits: layer i occupies bits [(i+1)*3*CW-1 : i*3*CW], ordered {R,G,B}; layer 0 has the highest priority.
REQ-009 SHALL provide port rgb_bg, input, 3*CW bits: background colour.
REQ-010 SHALL provide ports Red_level, Green_level and Blue_level, outputs, CW bits each: the selected pixel colour.
REQ-011 SHALL provide port draw_any, output, 1 bit: some layer won the current pixel.
REQ-012 SHALL provide port top_layer, output, 3 bits: index of the winning layer.
REQ-013 SHALL provide port coll_live, output, N_LAYERS bits: running per-layer collision flags for the current frame.
REQ-014 SHALL provide port coll_frame, output, N_LAYERS bits: per-layer collision flags of the last completed frame.
REQ-015 SHALL provide port coll_pixels, output, 16 bits: number of collision pixels in the last completed frame.
REQ-016 SHALL provide port coll_valid, output, 1 bit: one-cycle pulse when coll_frame and coll_pixels update.

Function
REQ-017 SHALL define active = draw & layer_en, evaluated each cycle.
REQ-018 SHALL select the winner as the lowest index i with active[i] set.
REQ-019 SHALL register the winner's colour, draw_any=1 and top_layer=i, giving exactly 1 cycle latency from inputs to outputs.
REQ-020 SHALL, when active is 0, output rgb_bg with draw_any=0 and top_layer=0, after the same 1 cycle latency.
REQ-021 SHALL treat a cycle with popcount(active)>=2 as a collision pixel; any disabled layer (layer_en=0) never wins and never collides.
REQ-022 SHALL, on a collision pixel without frame_start, OR active into the accumulator and increment the 16-bit pixel counter, saturating at 0xFFFF.
REQ-023 SHALL drive coll_live from the registered accumulator.
REQ-024 SHALL, on a cycle with frame_start=1, copy the accumulator and counter into coll_frame and coll_pixels, and assert coll_valid on the following cycle only.
REQ-025 SHALL, in that same frame_start cycle, reload the accumulator with active and the counter with 1 if that cycle is a collision pixel, else with 0 and 0.
REQ-026 SHALL take new frame_start pulses on back-to-back cycles as valid frames, each producing its own snapshot and coll_valid pulse.
REQ-027 SHALL apply a layer_en change from the next evaluated pixel, with no effect on already-accumulated flags.

Reset
REQ-028 SHALL, while resetN=0, force Red_level, Green_level, Blue_level, draw_any, top_layer, coll_live, coll_frame, coll_pixels, coll_valid and all internal state to 0, immediately and regardless of clk.
REQ-029 SHALL begin the first post-reset frame with an empty accumulator; a reset mid-frame discards that partial frame.

Configuration
REQ-030 SHALL compile the collision logic of REQ-021..REQ-027 only when macro DRAWING_COLLISION_EN is defined.
REQ-031 SHALL, without DRAWING_COLLISION_EN, tie coll_live, coll_frame, coll_pixels and coll_valid to constant 0 and instantiate no accumulator or counter; the priority path is unchanged.

Verification
REQ-032 Bench SHALL cover: N=4, draw=4'b0110, layer_en=4'hF, layer1 rgb=12'hF00 -> next cycle RGB=F,0,0, top_layer=1, draw_any=1.
REQ-033 Bench SHALL cover: draw=0, rgb_bg=12'hFFF -> next cycle RGB=F,F,F, draw_any=0, top_layer=0.
REQ-034 Bench SHALL cover: draw=4'b0011 with layer_en=4'b1110 -> layer 1 wins, and no collision is counted.
REQ-035 Bench SHALL cover: 5 cycles of draw=4'b1001 within a frame, then frame_start -> coll_frame=4'b1001, coll_pixels=5, coll_valid high for exactly 1 cycle.
REQ-036 Bench SHALL cover: 70000 collision pixels in one frame -> coll_pixels=0xFFFF at snapshot.
REQ-037 Bench SHALL cover: resetN pulled low mid-frame, asynchronously -> all outputs 0 at once, and the next snapshot excludes the pre-reset pixels.
